// File: rtl/wrr_lock_n_arb_pkg.sv
// Package arb_pkg: shared types and helpers for the weighted round-robin
// arbiter with packet lock.
//   state_t       : arbiter FSM states (IDLE = no grant, BUSY = grant held)
//   thermo_above  : mask with every bit strictly above idx set, limited to n bits
//   onehot2bin    : binary index of a one-hot vector (0 for all zeros)
// Helpers work on a MAX_N wide vector; callers size-cast to their own N.
package arb_pkg;

  localparam int MAX_N = 64;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [MAX_N-1:0] thermo_above(input int idx, input int n);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_N; i++) begin
      m[i] = (i > idx) && (i < n);
    end
    return m;
  endfunction

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic int onehot2bin(input logic [MAX_N-1:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) b = b | i;
    end
    return b;
  endfunction

endpackage

// File: rtl/wrr_lock_n_arb_pick.sv
// rr_pick_n: combinational rotating-priority pick.
// Lowest set index of req&ptr wins; if that is empty, lowest set index of req.
//   req  in  N  request vector
//   ptr  in  N  thermometer priority mask (bits eligible in the first pass)
//   win  out N  one-hot winner, zero when no request
//   any  out 1  |req
module rr_pick_n #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win,
  output logic         any
);

  logic [N-1:0] masked;
  logic [N-1:0] win_m;
  logic [N-1:0] win_r;
  // seen_x[i] = some bit below i is set; seen_x[N] doubles as the OR of all.
  logic [N:0]   seen_m;
  logic [N:0]   seen_r;

  assign masked    = req & ptr;
  assign seen_m[0] = 1'b0;
  assign seen_r[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_chain
    assign seen_m[gi+1] = seen_m[gi] | masked[gi];
    assign seen_r[gi+1] = seen_r[gi] | req[gi];
    assign win_m[gi]    = masked[gi] & ~seen_m[gi];
    assign win_r[gi]    = req[gi] & ~seen_r[gi];
  end

  assign win = seen_m[N] ? win_m : win_r;
  assign any = seen_r[N];

endmodule

// File: rtl/wrr_lock_n_arb.sv
// wrr_lock_n_arb: N-way weighted round-robin arbiter with packet lock.
// A winner keeps its registered grant until it has sent weight[g] complete
// packets or goes idle at a packet boundary; a packet in flight is never cut.
//   clk, rst     clock, synchronous active-high reset
//   req[N]       per-requester request / beat valid while granted
//   last[N]      end-of-packet flag, qualified by req
//   weight[N*CW] packets per turn (0 treated as 1), sampled at grant start
//   gnt_ready    downstream accepts a beat this cycle
//   grant[N]     registered one-hot grant
//   grant_valid  |grant
//   grant_idx    binary index of grant, 0 when no grant
//   beat_acc     beat transferred this cycle (combinational)
module wrr_lock_n_arb
  import arb_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  last,
  input  logic [N*CW-1:0] weight,
  input  logic          gnt_ready,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic          beat_acc
);

  state_t        state_reg;
  logic [N-1:0]  grant_reg;
  logic [N-1:0]  ptr_reg;
  logic [IW-1:0] idx_reg;
  logic [CW-1:0] credit_reg;
  logic          in_pkt_reg;

  logic          g_req;
  logic          g_last;
  logic          rel_now;
  logic          do_load;
  logic [N-1:0]  ptr_rel;
  logic [N-1:0]  ptr_eff;
  logic [N-1:0]  win;
  logic          any;
  logic [IW-1:0] win_idx;
  logic [CW-1:0] w_sel;
  logic [CW-1:0] win_credit;

  assign g_req       = req[idx_reg];
  assign g_last      = last[idx_reg];
  assign grant_valid = |grant_reg;
  assign beat_acc    = grant_valid & g_req & gnt_ready;

  // Release on the last beat of the final credited packet, or when the
  // holder is between packets and has stopped requesting.
  assign rel_now = (state_reg == BUSY) &
                   ((beat_acc & g_last & (credit_reg == CW'(1))) |
                    (~in_pkt_reg & ~g_req));

  // The pick sees the post-release mask in the same cycle so the releasing
  // requester is already lowest priority for the back-to-back handover.
  assign ptr_rel = N'(thermo_above(int'(idx_reg), N));
  assign ptr_eff = rel_now ? ptr_rel : ptr_reg;

  rr_pick_n #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_eff),
    .win (win),
    .any (any)
  );

  assign win_idx    = IW'(onehot2bin(MAX_N'(win)));
  assign w_sel      = weight[win_idx*CW +: CW];
  assign win_credit = (w_sel == '0) ? CW'(1) : w_sel;
  assign do_load    = any & ((state_reg == IDLE) | rel_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      idx_reg    <= '0;
      ptr_reg    <= '1;
      credit_reg <= '0;
      in_pkt_reg <= 1'b0;
    end else begin
      if (rel_now) begin
        ptr_reg <= ptr_rel;
      end
      if (do_load) begin
        state_reg  <= BUSY;
        grant_reg  <= win;
        idx_reg    <= win_idx;
        credit_reg <= win_credit;
        in_pkt_reg <= 1'b0;
      end else if (rel_now) begin
        state_reg  <= IDLE;
        grant_reg  <= '0;
        idx_reg    <= '0;
        credit_reg <= '0;
        in_pkt_reg <= 1'b0;
      end else if (beat_acc) begin
        if (g_last) begin
          in_pkt_reg <= 1'b0;
          credit_reg <= credit_reg - CW'(1);
        end else begin
          in_pkt_reg <= 1'b1;
        end
      end
    end
  end

  assign grant     = grant_reg;
  assign grant_idx = idx_reg;

endmodule
